// File: rtl/zimbo_pkg.sv
// Shared fetch-side definitions: default widths, reset PC and the fetch-entry layout.
package zimbo_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    localparam logic [AW_DEF-1:0] RESET_PC = 16'h0000;

    typedef struct packed {
        logic [AW_DEF-1:0] pc;
        logic [DW_DEF-1:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_ram.sv
// Fetch queue storage: per-entry PC tag and instruction word.
// Tags and words are written independently; the read port is asynchronous.
module ifetch_ram
    import zimbo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          tag_we,
    input  logic [PW-1:0] tag_waddr,
    input  logic [AW-1:0] tag_wdata,
    input  logic          word_we,
    input  logic [PW-1:0] word_waddr,
    input  logic [DW-1:0] word_wdata,
    input  logic [PW-1:0] raddr,
    output logic [AW-1:0] rtag,
    output logic [DW-1:0] rword
);

    logic [AW-1:0] tag_q  [DEPTH];
    logic [DW-1:0] word_q [DEPTH];

    // Cleared on reset so the head outputs read as zero afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                word_q[i] <= '0;
            end
        end else begin
            if (tag_we)  tag_q[tag_waddr]   <= tag_wdata;
            if (word_we) word_q[word_waddr] <= word_wdata;
        end
    end

    assign rtag  = tag_q[raddr];
    assign rword = word_q[raddr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues reads at the PC, buffers returned words in
// order for decode, stalls the PC when full and drops stale data after a redirect.
module ifetch_queue
    import zimbo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] pc_addr,
    output logic          pc_en,
    input  logic          redirect,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [DW-1:0] imem_rdata,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] ONE  = (PW+1)'(1);

    logic [PW:0] alloc_q, alloc_d;
    logic [PW:0] fill_q, fill_d;
    logic [PW:0] read_q, read_d;
    logic [PW:0] discard_q, discard_d;

    logic [PW:0] inflight, buffered, used;
    logic        fire, fill_en, pop;

    assign inflight = alloc_q - fill_q;
    assign buffered = fill_q - read_q;
    assign used     = alloc_q - read_q;

    assign imem_req    = !reset && !redirect && (used < FULL);
    assign imem_addr   = pc_addr;
    assign fire        = imem_req && imem_gnt;
    assign pc_en       = !reset && (fire || redirect);
    assign instr_valid = !reset && !redirect && (buffered != '0);
    assign pop         = instr_valid && instr_ready;
    assign fill_en     = !reset && !redirect && imem_rvalid && (discard_q == '0);

    always_comb begin
        alloc_d   = alloc_q;
        fill_d    = fill_q;
        read_d    = read_q;
        discard_d = discard_q;
        if (redirect) begin
            // Everything still owed by memory becomes stale; a response landing
            // this cycle is already one of them.
            fill_d    = alloc_q;
            read_d    = alloc_q;
            discard_d = discard_q + inflight - {{PW{1'b0}}, imem_rvalid};
        end else begin
            if (fire) alloc_d = alloc_q + ONE;
            if (fill_en) begin
                fill_d = fill_q + ONE;
            end else if (imem_rvalid) begin
                discard_d = discard_q - ONE;
            end
            if (pop) read_d = read_q + ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            alloc_q   <= '0;
            fill_q    <= '0;
            read_q    <= '0;
            discard_q <= '0;
        end else begin
            alloc_q   <= alloc_d;
            fill_q    <= fill_d;
            read_q    <= read_d;
            discard_q <= discard_d;
        end
    end

    ifetch_ram #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .DW   (DW),
        .PW   (PW)
    ) u_ram (
        .clock     (clock),
        .reset     (reset),
        .tag_we    (fire),
        .tag_waddr (alloc_q[PW-1:0]),
        .tag_wdata (pc_addr),
        .word_we   (fill_en),
        .word_waddr(fill_q[PW-1:0]),
        .word_wdata(imem_rdata),
        .raddr     (read_q[PW-1:0]),
        .rtag      (instr_pc),
        .rword     (instr)
    );

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: behavioural PC register and in-order memory model,
// expected fetch streams queued by the stimulus and checked by a pop monitor.
module tb_ifetch_queue;
    import zimbo_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset, redirect, imem_gnt, imem_rvalid, instr_ready;
    logic [AW-1:0] pc_addr, tgt;
    logic [DW-1:0] imem_rdata;
    logic          pc_en, imem_req, instr_valid;
    logic [AW-1:0] imem_addr, instr_pc;
    logic [DW-1:0] instr;

    int n_chk  = 0;
    int n_fail = 0;
    int mem_lat = 1;
    int cyc = 0;

    logic [AW-1:0] exp_q [$];
    fetch_entry_t  pend_q [$];
    int            due_q [$];

    ifetch_queue #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .pc_addr    (pc_addr),
        .pc_en      (pc_en),
        .redirect   (redirect),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .instr_pc   (instr_pc)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] wfun(input logic [AW-1:0] a);
        return a ^ 16'hA5A5;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // PC register and memory: sample just before the edge, update just after.
    initial begin
        logic g, pe, rd, rs;
        logic [AW-1:0] ga, tg;
        pc_addr = RESET_PC;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clock); #4;
            rs = reset; g = imem_req & imem_gnt; ga = imem_addr;
            pe = pc_en; rd = redirect; tg = tgt;
            @(posedge clock); #1;
            if (rs) begin
                pc_addr = RESET_PC;
                pend_q.delete();
                due_q.delete();
            end else begin
                if (pe) pc_addr = rd ? tg : pc_addr + 16'd1;
                if (g) begin
                    pend_q.push_back('{pc: ga, word: wfun(ga)});
                    due_q.push_back(cyc + mem_lat);
                end
            end
            cyc++;
            imem_rvalid = 1'b0;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend_q[0].word;
                void'(pend_q.pop_front());
                void'(due_q.pop_front());
            end
        end
    end

    // Pop monitor
    initial begin
        logic [AW-1:0] e;
        forever begin
            @(negedge clock); #4;
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_pop: got instr_pc %h expected no instruction", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr_pc", instr_pc, e);
                    chk("instr", instr, wfun(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; redirect = 1'b0; imem_gnt = 1'b1; instr_ready = 1'b0; tgt = '0;

        // Reset: outputs quiet even with a grant offered
        tick; tick; #4;
        chk("rst_req", imem_req, 0);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        tick; reset = 1'b0; imem_gnt = 1'b0; #4;
        chk("post_rst_valid", instr_valid, 0);
        chk("post_rst_instr_pc", instr_pc, 0);
        chk("post_rst_req", imem_req, 1);

        // Streaming with 1-cycle memory: PCs 0..9
        for (int i = 0; i < 10; i++) exp_q.push_back(16'(i));
        instr_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick; imem_gnt = 1'b1; #4;
            chk("stream_pc_en", pc_en, 1);
            chk("stream_addr", imem_addr, 32'(i));
        end
        tick; imem_gnt = 1'b0;
        repeat (6) tick;
        chk("drain_stream", exp_q.size(), 0);
        chk("stream_pc_end", pc_addr, 16'd10);

        // Full queue stalls the PC at 14
        instr_ready = 1'b0;
        for (int i = 10; i < 14; i++) exp_q.push_back(16'(i));
        for (int i = 0; i < 6; i++) begin tick; imem_gnt = 1'b1; end
        #4;
        chk("full_req", imem_req, 0);
        chk("full_pc_en", pc_en, 0);
        chk("full_pc_hold", pc_addr, 16'd14);
        tick; imem_gnt = 1'b0; instr_ready = 1'b1;
        repeat (6) tick;
        chk("drain_full", exp_q.size(), 0);
        chk("full_pc_after", pc_addr, 16'd14);
        for (int i = 14; i < 17; i++) exp_q.push_back(16'(i));
        tick; imem_gnt = 1'b1;
        tick; tick;
        tick; imem_gnt = 1'b0;
        repeat (6) tick;
        chk("drain_refetch", exp_q.size(), 0);

        // Redirect with 3-cycle memory, 2 in flight and 1 buffered
        mem_lat = 3; instr_ready = 1'b0;
        tick; imem_gnt = 1'b1;                    // grant 17
        tick; imem_gnt = 1'b0;
        tick; imem_gnt = 1'b1;                    // grant 18
        tick;                                     // grant 19, 17 returns
        tick; redirect = 1'b1; tgt = 16'h0040; #4;
        chk("redir_valid", instr_valid, 0);
        chk("redir_req", imem_req, 0);
        chk("redir_pc_en", pc_en, 1);
        exp_q.push_back(16'h0040); exp_q.push_back(16'h0041); exp_q.push_back(16'h0042);
        tick; redirect = 1'b0; instr_ready = 1'b1; #4;
        chk("redir_next_valid", instr_valid, 0);
        chk("redir_next_addr", imem_addr, 16'h0040);
        chk("redir_next_pc_en", pc_en, 1);
        tick; tick;
        tick; imem_gnt = 1'b0;
        repeat (10) tick;
        chk("drain_redir", exp_q.size(), 0);
        chk("redir_pc_end", pc_addr, 16'h0043);

        // Redirect coincident with a returning response
        tick; imem_gnt = 1'b1;                    // grant 0x43
        tick;                                     // grant 0x44
        tick; imem_gnt = 1'b0;
        tick; redirect = 1'b1; tgt = 16'h0080; imem_gnt = 1'b1; #4;
        chk("coinc_rvalid_req", imem_req, 0);
        exp_q.push_back(16'h0080); exp_q.push_back(16'h0081);
        tick; redirect = 1'b0;                    // grant 0x80, 0x44 dropped
        tick;                                     // grant 0x81
        tick; imem_gnt = 1'b0;
        repeat (10) tick;
        chk("drain_coinc", exp_q.size(), 0);

        // Reset with requests in flight and a valid head
        instr_ready = 1'b0;
        tick; imem_gnt = 1'b1;                    // grant 0x82
        tick; imem_gnt = 1'b0;
        tick; imem_gnt = 1'b1;                    // 0x83
        tick;                                     // 0x84
        tick; #4;                                 // 0x85
        chk("pre_rst_valid", instr_valid, 1);
        chk("pre_rst_head", instr_pc, 16'h0082);
        tick; reset = 1'b1; #4;
        chk("mid_rst_req", imem_req, 0);
        chk("mid_rst_pc_en", pc_en, 0);
        chk("mid_rst_valid", instr_valid, 0);
        tick; reset = 1'b0; imem_gnt = 1'b0; #4;
        chk("after_rst_valid", instr_valid, 0);
        chk("after_rst_instr", instr, 0);
        chk("after_rst_instr_pc", instr_pc, 0);
        repeat (5) tick;
        #4;
        chk("after_rst_drain_valid", instr_valid, 0);
        chk("after_rst_pc", pc_addr, 16'h0000);

        // Grant toggling: pc_en tracks grants, PCs 0..4 with no gaps
        mem_lat = 1; instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(16'(i));
        for (int i = 0; i < 10; i++) begin
            tick; imem_gnt = (i % 2 == 0); #4;
            chk("toggle_pc_en", pc_en, 32'(i % 2 == 0));
        end
        tick; imem_gnt = 1'b0;
        repeat (6) tick;
        chk("drain_toggle", exp_q.size(), 0);
        chk("toggle_pc_end", pc_addr, 16'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Fetch-side consumer of the program counter: issues instruction-memory reads at the current PC and tags each with its address.
- Buffers returned instruction words in order and presents them to decode with a valid/ready handshake.
- Drives the PC enable back to the pc register, which is the stall path.
- On branch/jump redirect, flushes queued words and discards stale in-flight responses.

Parameters:
- DEPTH, 4: entries in the tag/data queue and the maximum outstanding plus buffered fetches; power of 2, ≥2.
- AW, 16: instruction address width; matches the PC width.
- DW, 16: instruction word width.

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- pc_addr  in  AW  current PC value (pc register output)
- pc_en  out  1  advance/load enable to pc register
- redirect  in  1  branch or jump taken this cycle; pc register loads the target when pc_en=1
- imem_req  out  1  read request valid
- imem_addr  out  AW  read address (= pc_addr)
- imem_gnt  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  read data returning; strictly in request order, at least 1 cycle after grant
- imem_rdata  in  DW  returned instruction word
- instr_valid  out  1  head entry filled and presentable
- instr_ready  in  1  decode accepts the head entry
- instr  out  DW  head instruction word
- instr_pc  out  AW  address of head instruction

Behaviour:
- Storage: circular queue of DEPTH entries, each {pc tag, word, filled}. Three pointers (alloc, fill, read), each log2(DEPTH)+1 bits with a wrap bit.
  - inflight = alloc-fill
  - buffered = fill-read
  - used = alloc-read
- Reset (synchronous, highest priority):
  - all pointers = 0, discard_cnt = 0
  - imem_req=0, instr_valid=0, pc_en=0
  - instr, instr_pc = 0
- Issue:
  - imem_req = !reset & !redirect & (used < DEPTH).
  - fire = imem_req & imem_gnt. On fire, write pc_addr to tag[alloc] and increment alloc.
  - imem_addr = pc_addr, combinational.
- pc_en = fire | redirect, combinational. The PC advances exactly once per accepted request and always loads the redirect target.
- Response:
  - When imem_rvalid and discard_cnt==0: write imem_rdata to word[fill] and increment fill.
  - When imem_rvalid and discard_cnt>0: decrement discard_cnt and drop the data.
- Output:
  - instr_valid = (buffered != 0) & !redirect.
  - instr and instr_pc come from entry[read], combinational from registers.
  - On instr_valid & instr_ready, increment read.
  - A response and a pop in the same cycle are both honoured.
- Redirect (wins over issue, pop and fill in the same cycle):
  - read = fill = alloc (queue empty).
  - discard_cnt = discard_cnt + inflight - (imem_rvalid ? 1 : 0); the response consumed this cycle is counted as discarded.
  - No request is issued that cycle.
  - From the next cycle, fetch resumes at the new pc_addr; the first issue is at cycle redirect+1 at the earliest.
  - Back-to-back redirects accumulate discard_cnt correctly.
- Full: when used==DEPTH, imem_req=0 and pc_en=0, so the PC holds.
- Empty: instr_valid=0; instr/instr_pc hold the last entry's values (don't-care).
- Pointer wrap: wrap bits distinguish full from empty. Wrap-around with alloc ≠ read is normal.
- Width: discard_cnt is log2(DEPTH)+1 bits and never exceeds DEPTH.
- Latency:
  - grant at cycle N, rvalid at N+k → instr_valid at N+k+1 if the queue was otherwise empty.
  - Throughput is 1 instruction/cycle with a 1-cycle memory and ready held high.

Decomposition:
- Shared package (zimbo_pkg):
  - AW/DW defaults
  - RESET_PC = 16'h0000
  - fetch-entry struct {pc, word}
- Sub-module ifetch_ram: DEPTH×(AW+DW) register array, one write port for tag, one write port for word, async read. Pointer and discard logic stay in ifetch_queue.

Test Plan:
- Reset, 1-cycle memory, imem_gnt=1, instr_ready=1, pc_addr stepping 0,1,2… → instr_pc/instr stream 0,1,2… one per cycle from cycle 3; pc_en=1 every cycle.
- instr_ready=0 with DEPTH=4 → after 4 grants imem_req=0 and pc_en=0 with pc_addr held at 4. Raising ready pops entries 0..3 in order and refetch resumes at 4.
- 3-cycle memory latency, redirect with 2 requests in flight and 1 buffered word → queue empties, instr_valid=0 next cycle. The next 2 rvalids are dropped; the first delivered instr_pc equals the redirect target 0x0040.
- Redirect coincident with imem_rvalid and 2 in flight → only 1 further response dropped; discard_cnt returns to 0.
- Assert reset while 3 requests are in flight and instr_valid=1 → next cycle all outputs are 0. Late rvalids after reset are written as fresh data only if requests were re-issued; the bench holds imem_rvalid=0 for the post-reset drain.
- imem_gnt toggling 1/0 with ready=1 → pc_en pulses exactly on grant cycles. Every instr_pc matches the pc_addr sampled at its grant, with no duplicates or gaps.
